// File: rtl/brq_lsu_pkg.sv
// Shared types and lane-select constants for the brq load/store unit.
// The lane code tells the DCCM which byte lanes of the word a store touches.
package brq_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic [2:0] BE_B0   = 3'b000;
    localparam logic [2:0] BE_B1   = 3'b001;
    localparam logic [2:0] BE_B2   = 3'b010;
    localparam logic [2:0] BE_B3   = 3'b011;
    localparam logic [2:0] BE_HI   = 3'b100;
    localparam logic [2:0] BE_LO   = 3'b101;
    localparam logic [2:0] BE_W    = 3'b110;
    localparam logic [2:0] BE_NONE = 3'b111;

    function automatic logic [2:0] lane_code(input logic [1:0] size, input logic [1:0] off);
        case (size)
            BYTE:    return {1'b0, off};
            HALF:    return off[1] ? BE_HI : BE_LO;
            WORD:    return BE_W;
            default: return BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/brq_lsu_load_align.sv
// Picks the addressed byte or half out of a DCCM read word and extends it.
// Word loads pass through untouched; an illegal size yields zero.
module brq_lsu_load_align
    import brq_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_i)
            2'b00:   byte_v = word_i[7:0];
            2'b01:   byte_v = word_i[15:8];
            2'b10:   byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (size_i)
            BYTE:    data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            HALF:    data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            WORD:    data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/brq_lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP (errors skip ACCESS).
// All DCCM-facing signals come straight from flops so the memory sees clean strobes.
module brq_lsu
    import brq_lsu_pkg::*;
#(
    parameter int          DataWidth = 32,
    parameter int          AddrWidth = 15,
    parameter logic [31:0] DccmBase  = 32'h0000_0000
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AddrWidth-1:0] dccm_address,
    output logic [2:0]           dccm_byte_enable,
    output logic [DataWidth-1:0] dccm_data_in,
    output logic                 dccm_write_enable,
    output logic                 dccm_read_enable,
    input  logic [DataWidth-1:0] dccm_data_out
);

    state_e state_q, state_d;

    logic [1:0]           size_q;
    logic [1:0]           off_q;
    logic                 unsigned_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;
    logic [AddrWidth-1:0] dccm_addr_q;
    logic [2:0]           be_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 dwe_q;
    logic                 dre_q;

    logic                 size_bad;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 req_err;
    logic [31:0]          load_data;

    // Request legality is judged on the live inputs so the IDLE decision is single-cycle.
    assign size_bad     = (req_size == 2'b11);
    assign misaligned   = ((req_size == HALF) && req_addr[0]) ||
                          ((req_size == WORD) && (req_addr[1:0] != 2'b00));
    assign out_of_range = (req_addr[31:AddrWidth+2] != DccmBase[31:AddrWidth+2]);
    assign req_err      = size_bad | misaligned | out_of_range;

    brq_lsu_load_align u_load_align (
        .word_i     (dccm_data_out),
        .addr_i     (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            unsigned_q  <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            dccm_addr_q <= '0;
            be_q        <= BE_NONE;
            wdata_q     <= '0;
            dwe_q       <= 1'b0;
            dre_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        off_q      <= req_addr[1:0];
                        unsigned_q <= req_unsigned;
                        if (req_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            err_q       <= 1'b0;
                            dccm_addr_q <= req_addr[AddrWidth+1:2];
                            be_q        <= lane_code(req_size, req_addr[1:0]);
                            wdata_q     <= req_wdata;
                            dwe_q       <= req_we;
                            dre_q       <= ~req_we;
                        end
                    end
                end
                ACCESS: begin
                    dwe_q   <= 1'b0;
                    dre_q   <= 1'b0;
                    be_q    <= BE_NONE;
                    // Stores answer with zero data; loads capture the read word at this edge.
                    rdata_q <= dre_q ? load_data : '0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata         = rdata_q;
    assign rsp_err           = err_q;
    assign dccm_address      = dccm_addr_q;
    assign dccm_byte_enable  = be_q;
    assign dccm_data_in      = wdata_q;
    assign dccm_write_enable = dwe_q;
    assign dccm_read_enable  = dre_q;

endmodule

// File: tb/tb_brq_lsu.sv
// Bench for brq_lsu: a word-wide DCCM model, a byte-addressed reference model,
// an expected-response queue and a monitor that checks every presented response.
module tb_brq_lsu;

    localparam int          AW   = 15;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          brq_clk = 1'b0;
    logic          brq_rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] dccm_address;
    logic [2:0]    dccm_byte_enable;
    logic [31:0]   dccm_data_in;
    logic          dccm_write_enable;
    logic          dccm_read_enable;
    logic [31:0]   dccm_data_out;

    int total = 0;
    int bad = 0;

    logic [32:0] exp_q[$];
    bit [7:0]    ref_mem[int];
    logic [31:0] dccm[0:(1<<AW)-1];

    brq_lsu #(.DataWidth(32), .AddrWidth(AW), .DccmBase(BASE)) dut (
        .brq_clk           (brq_clk),
        .brq_rst_n         (brq_rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .dccm_address      (dccm_address),
        .dccm_byte_enable  (dccm_byte_enable),
        .dccm_data_in      (dccm_data_in),
        .dccm_write_enable (dccm_write_enable),
        .dccm_read_enable  (dccm_read_enable),
        .dccm_data_out     (dccm_data_out)
    );

    // Clock / reset
    always #5 brq_clk = ~brq_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DCCM environment: combinational read, lane-coded write at the clock edge
    initial begin
        for (int i = 0; i < (1 << AW); i++) dccm[i] = '0;
    end

    assign dccm_data_out = dccm[dccm_address];

    always @(posedge brq_clk) begin
        if (dccm_write_enable) begin
            case (dccm_byte_enable)
                3'b000: dccm[dccm_address][7:0]   <= dccm_data_in[7:0];
                3'b001: dccm[dccm_address][15:8]  <= dccm_data_in[7:0];
                3'b010: dccm[dccm_address][23:16] <= dccm_data_in[7:0];
                3'b011: dccm[dccm_address][31:24] <= dccm_data_in[7:0];
                3'b100: dccm[dccm_address][31:16] <= dccm_data_in[15:0];
                3'b101: dccm[dccm_address][15:0]  <= dccm_data_in[15:0];
                3'b110: dccm[dccm_address]        <= dccm_data_in;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, legality from size/alignment/range arithmetic
    function automatic bit ref_legal(input bit [1:0] size, input logic [31:0] addr);
        longint off;
        int n;
        if (size == 2'b11) return 1'b0;
        n = 1 << size;
        if ((addr % n) != 0) return 1'b0;
        off = longint'(addr) - longint'(BASE);
        if (off < 0 || off >= (longint'(1) << (AW + 2))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input bit [1:0] size, input bit uns, input logic [31:0] addr);
        int n = 1 << size;
        longint v = 0;
        for (int i = 0; i < n; i++) begin
            int k = int'(addr) + i;
            if (ref_mem.exists(k)) v = v | (longint'(ref_mem[k]) << (8 * i));
        end
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input bit [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 1 << size;
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    endtask

    function automatic logic [31:0] exp_be(input bit [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return {29'd0, 1'b0, addr[1:0]};
            2'd1:    return (addr % 4 == 2) ? 32'd4 : 32'd5;
            default: return 32'd6;
        endcase
    endfunction

    // Monitor: every presented response must match the head of the expected queue
    always @(negedge brq_clk) begin
        if (brq_rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0][32]});
                check("rsp_req_ready_low", {31'd0, req_ready}, 32'd0);
                check("rsp_no_strobes", {30'd0, dccm_write_enable, dccm_read_enable}, 32'd0);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: issue one request, check ACCESS-cycle strobes, then hold and take the response
    task automatic do_req(input bit we, input bit [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        bit legal = ref_legal(size, addr);
        if (!legal)  exp_q.push_back({1'b1, 32'h0});
        else if (we) exp_q.push_back({1'b0, 32'h0});
        else         exp_q.push_back({1'b0, ref_load(size, uns, addr)});

        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge brq_clk); #1;
        // Junk on the request bus while busy must be ignored
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;

        if (legal) begin
            check("acc_we", {31'd0, dccm_write_enable}, {31'd0, we});
            check("acc_re", {31'd0, dccm_read_enable}, {31'd0, !we});
            check("acc_be", {29'd0, dccm_byte_enable}, exp_be(size, addr));
            check("acc_addr", {17'd0, dccm_address}, (addr - BASE) >> 2);
            if (we) check("acc_din", dccm_data_in, wdata);
            check("acc_rsp_low", {31'd0, rsp_valid}, 32'd0);
            @(posedge brq_clk); #1;
            if (we) ref_store(size, addr, wdata);
        end
        check("rsp_rise", {31'd0, rsp_valid}, 32'd1);
        check("post_we_off", {31'd0, dccm_write_enable}, 32'd0);
        check("post_re_off", {31'd0, dccm_read_enable}, 32'd0);
        check("post_be_none", {29'd0, dccm_byte_enable}, 32'd7);

        repeat (hold) begin
            @(posedge brq_clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge brq_clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, "_dccm_we"}, {31'd0, dccm_write_enable}, 32'd0);
        check({tag, "_dccm_re"}, {31'd0, dccm_read_enable}, 32'd0);
        check({tag, "_dccm_be"}, {29'd0, dccm_byte_enable}, 32'd7);
        check({tag, "_dccm_addr"}, {17'd0, dccm_address}, 32'd0);
        check({tag, "_dccm_din"}, dccm_data_in, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge brq_clk);
        #1;
        check_reset_values("reset");
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        @(posedge brq_clk); #1;

        // Word store then load
        do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1);
        // Byte store into a known word, then signed/unsigned/word reads
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h00000080, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0);
        // Upper-half store and half reads
        do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000BEEF, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 0);
        // Error requests
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 0);
        do_req(1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF, 0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, BASE + (32'h1 << (AW + 2)), 32'h0, 0);
        do_req(1'b1, 2'd2, 1'b0, BASE + (32'h1 << (AW + 2)), 32'h55AA55AA, 0);
        // Response back-pressure
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 5);

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            bit          we   = 1'($urandom_range(0, 1));
            bit [1:0]    size = 2'($urandom_range(0, 3));
            bit          uns  = 1'($urandom_range(0, 1));
            logic [31:0] addr;
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0002_0000;
            else                           addr = 32'($urandom_range(0, 63));
            do_req(we, size, uns, addr, $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of a store's ACCESS cycle
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        @(posedge brq_clk); #1;
        req_valid = 1'b0;
        check("rst_pre_we", {31'd0, dccm_write_enable}, 32'd1);
        #2;
        brq_rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(posedge brq_clk); #1;
        check("rst_word_kept", dccm[32'h40 >> 2], 32'hCAFEF00D);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        @(posedge brq_clk); #1;
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

        repeat (2) @(posedge brq_clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brq_lsu.md
# brq_lsu

Load/store unit sitting between the execute stage and the data closely-coupled memory (DCCM). Accepts one byte/half/word load or store per request through a valid/ready handshake and checks alignment and address range. Converts the byte address into the DCCM word address and lane-select code, then returns sign- or zero-extended load data, or a store acknowledge, through a held response handshake.

## Interface
- DataWidth, 32, data path width; only 32 is supported.
- AddrWidth, 15, DCCM word-address width (2^AddrWidth words).
- DccmBase, 32'h0000_0000, byte base address of the DCCM; must be aligned to 2^(AddrWidth+2).
- brq_clk  in  1  clock; all state changes on rising edge.
- brq_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present; held until taken.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal size.
- dccm_address  out  AddrWidth  word address.
- dccm_byte_enable  out  3  lane code, see Operation.
- dccm_data_in  out  32  store data.
- dccm_write_enable  out  1  write strobe; memory updates on the next rising edge.
- dccm_read_enable  out  1  read strobe.
- dccm_data_out  in  32  combinational read data for the current dccm_address.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_valid & req_ready latches req_* into request registers.
  - Legal request → ACCESS; otherwise → RESP with rsp_err=1 and no DCCM access.
- Error conditions:
  - req_size==11.
  - Half with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - addr[31:AddrWidth+2] ≠ DccmBase[31:AddrWidth+2].
- ACCESS (exactly one cycle):
  - dccm_address = addr_q[AddrWidth+1:2].
  - dccm_data_in = wdata_q.
  - Store: dccm_write_enable=1.
  - Load: dccm_read_enable=1, and dccm_data_out is captured at the closing edge.
  - Next state is RESP.
- Lane codes (dccm_byte_enable):
  - Byte: {1'b0, addr[1:0]}.
  - Half, addr[1]=1: 3'b100 (bits 31:16).
  - Half, addr[1]=0: 3'b101 (bits 15:0).
  - Word: 3'b110.
  - Outside ACCESS: 3'b111 (no lane).
- Load alignment:
  - Byte: lane addr[1:0] of the read word.
  - Half: upper half if addr[1]=1, else lower half.
  - Extension: sign-extend unless unsigned_q; word is passed through.
- RESP: rsp_valid=1, outputs stable; on rsp_ready → IDLE.
- DCCM strobes, address and lane code are registered, giving glitch-free outputs.

## Timing
- Reset values:
  - state IDLE.
  - req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - dccm_write_enable 0, dccm_read_enable 0.
  - dccm_byte_enable 3'b111, dccm_address 0, dccm_data_in 0.
- Legal request, accepted at edge N: ACCESS in cycle N..N+1; rsp_valid rises after edge N+1.
- Error request, accepted at edge N: rsp_valid rises after edge N; the DCCM strobes never assert.
- Throughput: at most one request per 3 cycles (error path: 2), plus response back-pressure.
- req_ready is 0 in ACCESS and RESP; req_valid there is ignored and not latched.
- rsp_valid & rsp_ready at edge M: rsp_valid=0 and req_ready=1 after M. There is no same-cycle re-accept.
- Reset asserted during ACCESS: write_enable drops asynchronously, so no DCCM write occurs at the next edge; any pending response is discarded.

## Structure
- Package brq_lsu_pkg holds:
  - size_e (BYTE, HALF, WORD).
  - state_e (IDLE, ACCESS, RESP).
  - Lane constants BE_B0..BE_B3, BE_HI, BE_LO, BE_W, BE_NONE.
- Sub-module brq_lsu_load_align (combinational): inputs word, addr[1:0], size, unsigned; output is the 32-bit extended result.
- Top holds the FSM, request registers, checks and DCCM drive; about 200 lines.

## Test plan
- sw 0xDEADBEEF @0x8, then lw @0x8 → write strobe for one cycle with be=110 and dccm_address=2; load response rdata=0xDEADBEEF, err=0.
- sb 0x80 @0x5 over 0x11223344, then lb @0x5 → rdata=0xFFFFFF80; lbu → 0x00000080; lw @0x4 → 0x11228044.
- sh 0xBEEF @0x6 → be=100; lh @0x6 → 0xFFFFBEEF; lhu → 0x0000BEEF; lh @0x4 is unaffected.
- lw @0x2, sh @0x1, size=11, and addr=DccmBase+2^(AddrWidth+2) → each gives rsp_err=1 with rdata=0, no strobes, and response one cycle after accept.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0; a new request is accepted only after the rsp handshake.
- Assert brq_rst_n=0 mid-ACCESS of a store → write_enable=0 immediately, target word unchanged, all outputs at reset values.
